// File: rtl/mem_responder_if.sv
// Request/response bus between the sequence controller (master) and the memory responder (slave).
// Strobes are level signals; ready and err are single-cycle pulses from the responder.
interface mem_responder_if #(
   parameter int AWIDTH = 5,
   parameter int DWIDTH = 8
);
   logic              mem_rd;
   logic              mem_wr;
   logic [AWIDTH-1:0] addr;
   logic [DWIDTH-1:0] data_in;
   logic [DWIDTH-1:0] data_out;
   logic              ready;
   logic              busy;
   logic              err;

   modport master (
      output mem_rd, mem_wr, addr, data_in,
      input  data_out, ready, busy, err
   );

   modport slave (
      input  mem_rd, mem_wr, addr, data_in,
      output data_out, ready, busy, err
   );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the VeriRISC store: latches a request, waits WAIT_CYCLES,
// performs one read or write, pulses ready, and ignores level-held strobes until released.
module mem_responder #(
   parameter int AWIDTH      = 5,
   parameter int DWIDTH      = 8,
   parameter int WAIT_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst,
   mem_responder_if.slave  bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

   state_t            r_state;
   state_t            w_next;
   logic [AWIDTH-1:0] r_addr;
   logic              r_is_wr;
   logic [3:0]        r_cnt;
   logic [DWIDTH-1:0] r_data_out;
   logic              r_err;
   logic [DWIDTH-1:0] r_mem [2**AWIDTH];

   logic w_req_one;
   logic w_req_both;
   logic w_access;

   always_comb begin
      w_req_one  = bus.mem_rd ^ bus.mem_wr;
      w_req_both = bus.mem_rd & bus.mem_wr;
      w_access   = (r_state == S_WAIT) && (r_cnt == 4'd0);
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_req_one) w_next = S_WAIT;
         S_WAIT: if (r_cnt == 4'd0) w_next = S_RESP;
         S_RESP: w_next = (bus.mem_rd | bus.mem_wr) ? S_HOLD : S_IDLE;
         S_HOLD: if (!(bus.mem_rd | bus.mem_wr)) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Address and operation type are captured once at acceptance; later bus changes are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 4'd0;
         r_data_out <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_next;
         r_err   <= (r_state == S_IDLE) && w_req_both;
         if ((r_state == S_IDLE) && w_req_one) begin
            r_addr  <= bus.addr;
            r_is_wr <= bus.mem_wr;
            r_cnt   <= LP_WAIT;
         end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_access && !r_is_wr) r_data_out <= r_mem[r_addr];
      end
   end

   // The array is never cleared; a reset on the access edge drops the pending write.
   always_ff @(posedge clk) begin
      if (!rst && w_access && r_is_wr) r_mem[r_addr] <= bus.data_in;
   end

   assign bus.data_out = r_data_out;
   assign bus.ready    = (r_state == S_RESP);
   assign bus.busy     = (r_state == S_WAIT) || (r_state == S_RESP);
   assign bus.err      = r_err;
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the sequence controller's mem_rd/mem_wr strobes; owns the instruction/data store of the VeriRISC system.
- Latches the address when a request is first seen and inserts a programmable number of wait states.
- Performs the read or write, then returns a one-cycle ready pulse.
- Tolerates level-held strobes that stay high across several controller states.

Parameters:
AWIDTH, 5, address width; memory depth is 2**AWIDTH words
DWIDTH, 8, data word width
WAIT_CYCLES, 1, wait states inserted before the access edge (legal range 0..15)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
mem_rd  input  1  read request, level
mem_wr  input  1  write request, level
addr  input  AWIDTH  word address, sampled when a request is accepted
data_in  input  DWIDTH  write data, sampled on the access edge
data_out  output  DWIDTH  last completed read data, registered
ready  output  1  one-cycle completion pulse
busy  output  1  high in WAIT and RESP
err  output  1  one-cycle pulse when mem_rd and mem_wr are both seen in IDLE

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of clk.
  - Outputs: state=IDLE, data_out=0, ready=0, busy=0, err=0, wait counter=0.
  - Memory array contents are not cleared.
  - Reset mid-operation: any in-flight access is abandoned; a pending write is not committed.
- FSM states: IDLE, WAIT, RESP, HOLD.
- IDLE:
  - mem_rd xor mem_wr: latch addr and operation type, load counter with WAIT_CYCLES, go to WAIT.
  - Both strobes high: err=1 for the next cycle, no access, stay IDLE.
  - Neither strobe high: stay IDLE.
- WAIT:
  - counter != 0: decrement, stay.
  - counter == 0 (the access edge), then go to RESP:
    - read: data_out <= mem[addr_q];
    - write: mem[addr_q] <= data_in.
  - Changes on addr, mem_rd or mem_wr during WAIT are ignored.
  - The operation completes even if the strobe drops.
- RESP:
  - ready=1 for exactly this one cycle.
  - Next state is HOLD if (mem_rd|mem_wr) is high, else IDLE.
- HOLD:
  - No new access while any strobe is high.
  - Return to IDLE when both strobes are low.
  - A level-held strobe therefore produces exactly one access.
- Latency: the request is sampled at edge E0; the access happens at edge E0+WAIT_CYCLES+1; ready is high in the cycle following that edge.
  - WAIT_CYCLES=0 gives ready 2 cycles after the request is first driven.
- Outputs:
  - ready, busy and err are decoded from registered state only.
  - data_out changes only on a read access edge or on reset.
  - A write never alters data_out.
- Read-after-write to the same address returns the newly written value; no bypass is needed because the accesses are serialized.
- Address wraps naturally within AWIDTH bits; no out-of-range condition exists.

Test Plan:
- Reset check: assert rst for 2 cycles while mem_rd=1 -> data_out=0, ready=0, busy=0, err=0; first request is accepted only after rst drops.
- Basic write/read, WAIT_CYCLES=1:
  - mem_wr=1, addr=5'h03, data_in=8'hA5 -> ready pulses 3 cycles after the strobe rises; data_out stays 0.
  - Then mem_rd=1, addr=5'h03 -> ready pulses once; data_out=8'hA5.
- Level-held strobe: hold mem_rd high for 6 cycles at addr=5'h03 -> exactly one ready pulse; FSM goes to HOLD and back to IDLE after mem_rd drops.
- Address change during WAIT (WAIT_CYCLES=3):
  - Issue a read at addr=5'h01 (contents 8'h11), then change addr to 5'h1F next cycle -> data_out=8'h11.
  - Wrap check: write 8'h3C to 5'h1F, read it back -> 8'h3C.
- Conflict: mem_rd=mem_wr=1 in IDLE -> err pulses 1 cycle, no ready, memory unchanged (read back of target address returns the prior value).
- Reset mid-write: assert rst during WAIT of a write of 8'hFF to 5'h02 (prior 8'h00) -> after reset, reading 5'h02 returns 8'h00; ready never pulsed for the aborted write.
